// File: rtl/pattern_seq_pkg.sv
// pattern_seq_pkg: shared widths and FSM state type for pattern_seq_ctrl
package pattern_seq_pkg;
  localparam int WORD_W   = 8;
  localparam int ADDR_W   = 4;
  localparam int BITCNT_W = 3;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
endpackage

// File: rtl/pattern_seq_ctrl_if.sv
// pattern_seq_ctrl_if: run control, memory and serial lines; master = requester/memory side, slave = controller (loop exists only with PSC_LOOP_EN)
interface pattern_seq_ctrl_if;
  import pattern_seq_pkg::*;
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] word_count;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_data;
  logic              serial_out;
  logic              serial_valid;
  logic              busy;
  logic              done;
`ifdef PSC_LOOP_EN
  logic              loop;
`endif
  modport master (
`ifdef PSC_LOOP_EN
    output loop,
`endif
    output start, abort, start_addr, word_count, mem_data,
    input  mem_addr, serial_out, serial_valid, busy, done
  );
  modport slave (
`ifdef PSC_LOOP_EN
    input  loop,
`endif
    input  start, abort, start_addr, word_count, mem_data,
    output mem_addr, serial_out, serial_valid, busy, done
  );
endinterface

// File: rtl/psc_word_shifter.sv
// psc_word_shifter: holds one pattern word and a bit counter; i_load captures i_data, i_shift advances, o_bit is the selected bit, o_last flags bit 7
module psc_word_shifter
  import pattern_seq_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clock,
  input  logic              clear_n,
  input  logic              i_load,
  input  logic              i_shift,
  input  logic [WORD_W-1:0] i_data,
  output logic              o_bit,
  output logic              o_last
);
  logic [WORD_W-1:0]   r_word;
  logic [BITCNT_W-1:0] r_cnt;
  always_ff @(posedge clock or negedge clear_n)
    if (!clear_n) begin
      r_word <= '0;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_word <= i_data;
      r_cnt  <= '0;
    end else if (i_shift)
      r_cnt <= r_cnt + BITCNT_W'(1);
  // ~r_cnt equals 7 - r_cnt for a 3-bit count, giving MSB-first order
  assign o_bit  = LSB_FIRST ? r_word[r_cnt] : r_word[~r_cnt];
  assign o_last = &r_cnt;
endmodule

// File: rtl/pattern_seq_ctrl.sv
// pattern_seq_ctrl: plays memory words out serially; clock, clear_n (async low) plus bus (slave modport); PSC_LOOP_EN adds looped replay
module pattern_seq_ctrl
  import pattern_seq_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic               clock,
  input  logic               clear_n,
  pattern_seq_ctrl_if.slave  bus
);
  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_rem;
  logic              r_valid;
  logic              r_busy;
  logic              r_done;
`ifdef PSC_LOOP_EN
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_len;
`endif
  logic w_bit;
  logic w_last;
  logic w_load;
  logic w_shift;
  assign w_load  = (r_state == LOAD)  && !bus.abort;
  assign w_shift = (r_state == SHIFT) && !bus.abort;
  psc_word_shifter #(.LSB_FIRST(LSB_FIRST)) u_shifter (
    .clock   (clock),
    .clear_n (clear_n),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_data  (bus.mem_data),
    .o_bit   (w_bit),
    .o_last  (w_last)
  );
  always_ff @(posedge clock or negedge clear_n)
    if (!clear_n) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_rem   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef PSC_LOOP_EN
      r_base  <= '0;
      r_len   <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE:
          if (bus.start && !bus.abort) begin
            r_addr  <= bus.start_addr;
            r_rem   <= bus.word_count;
`ifdef PSC_LOOP_EN
            r_base  <= bus.start_addr;
            r_len   <= bus.word_count;
`endif
            r_busy  <= 1'b1;
            r_state <= LOAD;
          end
        LOAD:
          if (bus.abort) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_valid <= 1'b1;
            r_state <= SHIFT;
          end
        SHIFT:
          if (bus.abort) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (w_last) begin
            r_valid <= 1'b0;
            if (r_rem != '0) begin
              r_addr  <= r_addr + ADDR_W'(1);
              r_rem   <= r_rem - ADDR_W'(1);
              r_state <= LOAD;
            end
`ifdef PSC_LOOP_EN
            else if (bus.loop) begin
              r_addr  <= r_base;
              r_rem   <= r_len;
              r_done  <= 1'b1;
              r_state <= LOAD;
            end
`endif
            else begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= DONE;
            end
          end
        default: r_state <= IDLE;
      endcase
    end
  assign bus.mem_addr     = r_addr;
  assign bus.serial_out   = r_valid & w_bit;
  assign bus.serial_valid = r_valid;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
endmodule

// File: doc/pattern_seq_ctrl.md
PATTERN_SEQ_CTRL -- requirements
Module: pattern_seq_ctrl

Interface
REQ-001 Parameter: LSB_FIRST, default 1, sets serial bit order within a word (1 = bit 0 first, 0 = bit 7 first).
REQ-002 clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 clear_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request a playback run; sampled only in IDLE.
REQ-005 abort  input  1  terminate the run in progress.
REQ-006 start_addr  input  4  first memory word of the run.
REQ-007 word_count  input  4  number of words minus one (1..16 words).
REQ-008 mem_addr  output  4  registered address to the pattern memory.
REQ-009 mem_data  input  8  combinational read data for mem_addr.
REQ-010 serial_out  output  1  current pattern bit.
REQ-011 serial_valid  output  1  serial_out is a live pattern bit.
REQ-012 busy  output  1  high in LOAD and SHIFT.
REQ-013 done  output  1  one-cycle pulse at normal run completion.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD, SHIFT and DONE.
REQ-015 IDLE with start=1 and abort=0: latch start_addr into mem_addr and word_count into a remaining counter; next state LOAD.
REQ-016 LOAD lasts one cycle: capture mem_data into the shift register, clear the 3-bit bit counter, go to SHIFT; serial_valid=0 in LOAD.
REQ-017 SHIFT: serial_valid=1; serial_out = shift register bit selected per LSB_FIRST; bit counter increments each cycle.
REQ-018 SHIFT at bit count 7: remaining=0 goes to DONE; otherwise mem_addr increments modulo 16 (15 wraps to 0), remaining decrements, next state LOAD.
REQ-019 Each word SHALL take exactly 9 cycles (1 LOAD + 8 SHIFT); done SHALL be high in the cycle following edge 9*(word_count+1), counting from the edge that samples start as edge 0.
REQ-020 DONE lasts one cycle with done=1, then returns to IDLE.
REQ-021 start outside IDLE SHALL be ignored; no queuing.
REQ-022 abort in LOAD or SHIFT: next state IDLE, serial_valid and busy low from the next cycle, no done pulse.
REQ-023 abort and start together in IDLE: start ignored.
REQ-024 serial_out SHALL be 0 whenever serial_valid=0.

Reset
REQ-025 clear_n low SHALL immediately force IDLE and drive mem_addr=0, serial_out=0, serial_valid=0, busy=0 and done=0, including mid-run; the shift register and counters also clear.
REQ-026 The first start after clear_n deasserts SHALL behave identically to a start from IDLE.

Configuration
REQ-027 Macro PSC_LOOP_EN: when defined, input loop (1 bit) SHALL exist; if loop=1 at SHIFT bit 7 of the final word, the block pulses done for one cycle concurrently, reloads the latched start_addr and word_count, and enters LOAD directly (no DONE state).
REQ-028 Without PSC_LOOP_EN: no loop port; every run ends through DONE.

Structure
REQ-029 Package pattern_seq_pkg SHALL hold the state enum and the constants WORD_W=8, ADDR_W=4 and BITCNT_W=3.
REQ-030 One sub-module, psc_word_shifter, SHALL hold the 8-bit load/select register and the bit counter.

Verification (memory: even addresses 0xCC, odd addresses 0xAA)
REQ-031 start_addr=0, word_count=1, LSB_FIRST=1 -> serial 0,0,1,1,0,0,1,1, then a one-cycle gap, then 0,1,0,1,0,1,0,1; done one cycle after edge 18.
REQ-032 start_addr=15, word_count=1 -> mem_addr 15 then 0; done after edge 18.
REQ-033 abort during the 3rd SHIFT cycle -> serial_valid/busy low next cycle, done never asserted; a following start runs normally.
REQ-034 word_count=15, start pulsed again mid-run -> exactly 16 words, second start ignored, done after edge 144.
REQ-035 clear_n low mid-SHIFT -> all outputs 0 asynchronously, state IDLE.
REQ-036 PSC_LOOP_EN, loop=1, word_count=0 -> continuous 9-cycle passes with a done pulse per pass; loop=0 -> ends via DONE.
